// File: rtl/poly_hint_pack_if.sv
// Handshake bundle between the make-hint stage, the hint packer and the
// signature byte packer. The master side drives start, polynomials and the
// byte-stream ready. The slave side is the packer.
interface poly_hint_pack_if;
   logic         start;
   logic         poly_valid;
   logic         poly_ready;
   logic [255:0] poly_h;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ready;
   logic         byte_last;
   logic         busy;
   logic         done;
   logic         reject;

   modport master (
      output start, poly_valid, poly_h, byte_ready,
      input  poly_ready, byte_out, byte_valid, byte_last, busy, done, reject
   );

   modport slave (
      input  start, poly_valid, poly_h, byte_ready,
      output poly_ready, byte_out, byte_valid, byte_last, busy, done, reject
   );
endinterface

// File: rtl/poly_hint_pack.sv
// Dilithium hint-section encoder. It scans K hint polynomials one
// coefficient per cycle and records the positions of the set bits in
// hint_buf[0..OMEGA-1]. It records the running weight after each polynomial
// in hint_buf[OMEGA+p], then streams all OMEGA+K bytes out. When the total
// weight exceeds OMEGA, the signature is flagged as rejected and nothing is
// streamed.
module poly_hint_pack #(
   parameter int K     = 4,
   parameter int OMEGA = 80
) (
   input  logic             clk,
   input  logic             rst_n,
   poly_hint_pack_if.slave  bus
);
   localparam int NB = OMEGA + K;
   localparam int IW = $clog2(NB);
   localparam int PW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SCAN,
      S_STORE,
      S_EMIT,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    hint_buf [NB];
   logic [255:0]  lat_h;
   logic [7:0]    k_cnt;
   logic [7:0]    coef_idx;
   logic [PW-1:0] poly_idx;
   logic [IW-1:0] out_idx;
   logic          reject_q;

   logic          cur_bit;
   logic          full;
   logic          last_poly;
   logic          last_byte;
   logic          clr;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [7:0]    wr_data;

   assign cur_bit   = lat_h[coef_idx];
   // k_cnt stops at OMEGA, so equality is the "no room left" test
   assign full      = (k_cnt == 8'(OMEGA));
   assign last_poly = (poly_idx == PW'(K - 1));
   assign last_byte = (out_idx == IW'(NB - 1));
   assign clr       = (state_q == S_IDLE) && bus.start;

   // Outputs decode from state. byte_out is forced to zero outside EMIT.
   assign bus.poly_ready = (state_q == S_WAIT);
   assign bus.byte_valid = (state_q == S_EMIT);
   assign bus.byte_last  = (state_q == S_EMIT) && last_byte;
   assign bus.byte_out   = (state_q == S_EMIT) ? hint_buf[out_idx] : 8'h00;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.reject     = reject_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: one coefficient per SCAN cycle; a rejected
   // signature skips EMIT entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_WAIT;
         S_WAIT:  if (bus.poly_valid) state_d = S_SCAN;
         S_SCAN:  if (coef_idx == 8'hFF) state_d = S_STORE;
         S_STORE: begin
            if (!last_poly)    state_d = S_WAIT;
            else if (reject_q) state_d = S_DONE;
            else               state_d = S_EMIT;
         end
         S_EMIT:  if (bus.byte_ready && last_byte) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Single buffer write port: an index during SCAN, a cumulative count in STORE
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state_q == S_SCAN && cur_bit && !full) begin
         wr_en   = 1'b1;
         wr_addr = IW'(k_cnt);
         wr_data = coef_idx;
      end else if (state_q == S_STORE) begin
         wr_en   = 1'b1;
         wr_addr = IW'(OMEGA) + IW'(poly_idx);
         wr_data = k_cnt;
      end
   end

   // Hint buffer: cleared on an accepted start so unused slots read zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB; i++) hint_buf[i] <= 8'h00;
      end else if (clr) begin
         for (int i = 0; i < NB; i++) hint_buf[i] <= 8'h00;
      end else if (wr_en) begin
         hint_buf[wr_addr] <= wr_data;
      end
   end

   // Counters, polynomial latch and reject flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_h    <= '0;
         k_cnt    <= '0;
         coef_idx <= '0;
         poly_idx <= '0;
         out_idx  <= '0;
         reject_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  k_cnt    <= '0;
                  poly_idx <= '0;
                  reject_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bus.poly_valid) begin
                  lat_h    <= bus.poly_h;
                  coef_idx <= '0;
               end
            end
            S_SCAN: begin
               coef_idx <= coef_idx + 8'd1;
               if (cur_bit) begin
                  if (!full) k_cnt    <= k_cnt + 8'd1;
                  else       reject_q <= 1'b1;
               end
            end
            S_STORE: begin
               out_idx <= '0;
               if (!last_poly) poly_idx <= poly_idx + PW'(1);
            end
            S_EMIT: begin
               if (bus.byte_ready) out_idx <= out_idx + IW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_poly_hint_pack.sv
// Scoreboard bench for poly_hint_pack. The driver builds the expected byte
// stream from the hint sets and pushes it into a queue. The monitor pops one
// entry per byte handshake. The monitor also drives byte_ready, either
// constant or random backpressure.
module tb_poly_hint_pack;
   localparam int K     = 4;
   localparam int OMEGA = 80;
   localparam int NB    = OMEGA + K;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   exp_t         exp_q[$];
   logic [255:0] pv[K];
   bit           bp_mode = 0;
   int           n_hs = 0;
   bit           seen_bv = 0;
   int           first_bv = 0;

   poly_hint_pack_if ifc ();

   poly_hint_pack #(.K(K), .OMEGA(OMEGA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "/poly_ready"}, 32'(ifc.poly_ready), 0);
      chk({nm, "/byte_out"},   32'(ifc.byte_out),   0);
      chk({nm, "/byte_valid"}, 32'(ifc.byte_valid), 0);
      chk({nm, "/byte_last"},  32'(ifc.byte_last),  0);
      chk({nm, "/busy"},       32'(ifc.busy),       0);
      chk({nm, "/done"},       32'(ifc.done),       0);
      chk({nm, "/reject"},     32'(ifc.reject),     0);
   endtask

   // Wait at negedges until poly_ready is seen; returns the cycle number
   task automatic wait_ready(input string nm, output int c);
      int n = 0;
      while (!ifc.poly_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "/poly_ready_timeout"}, 32'(ifc.poly_ready), 1);
      c = cyc;
   endtask

   // Monitor: drives byte_ready, pops/compares on each byte handshake,
   // and checks that outputs hold while stalled
   initial begin
      exp_t       e;
      bit         prev_stall = 0;
      logic [7:0] prev_byte = 0;
      logic       prev_last = 0;
      forever begin
         @(negedge clk);
         ifc.byte_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!rst_n) begin
            prev_stall = 0;
            continue;
         end
         if (prev_stall)
            chk("stall_hold", {ifc.byte_valid, ifc.byte_last, ifc.byte_out},
                {1'b1, prev_last, prev_byte});
         if (ifc.byte_valid) begin
            if (!seen_bv) begin
               seen_bv  = 1;
               first_bv = cyc;
            end
            if (ifc.byte_ready) begin
               n_hs++;
               chk("byte_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk($sformatf("byte[%0d]", n_hs - 1),
                      {ifc.byte_last, ifc.byte_out}, {e.last, e.b});
               end
               prev_stall = 0;
            end else begin
               prev_stall = 1;
               prev_byte  = ifc.byte_out;
               prev_last  = ifc.byte_last;
            end
         end else begin
            prev_stall = 0;
         end
      end
   end

   // One full signature using the hint sets in pv[]
   task automatic run_sig(input string nm, input bit bp);
      int   idx_q[$];
      int   cum[K];
      bit   rej;
      int   n, hs0, c, t_done;
      exp_t e;
      // reference: list every set bit in polynomial order, then cumulative counts
      for (int p = 0; p < K; p++) begin
         for (int b = 0; b < 256; b++)
            if (pv[p][b]) idx_q.push_back(b);
         cum[p] = idx_q.size();
      end
      rej = idx_q.size() > OMEGA;
      if (!rej) begin
         for (int i = 0; i < NB; i++) begin
            if (i >= OMEGA)           e.b = 8'(cum[i - OMEGA]);
            else if (i < idx_q.size()) e.b = 8'(idx_q[i]);
            else                       e.b = 8'h00;
            e.last = (i == NB - 1);
            exp_q.push_back(e);
         end
      end
      bp_mode = bp;
      n_hs    = 0;
      seen_bv = 0;

      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start      = 1'b0;
      ifc.poly_valid = 1'b1;
      chk({nm, "/busy_after_start"},  32'(ifc.busy), 1);
      chk({nm, "/ready_after_start"}, 32'(ifc.poly_ready), 1);
      chk({nm, "/reject_cleared"},    32'(ifc.reject), 0);
      hs0 = 0;
      for (int i = 0; i < K; i++) begin
         ifc.poly_h = pv[i];
         wait_ready(nm, c);
         if (i == 0) hs0 = c;
         @(negedge clk);
         if (i == 0) begin
            // a start while scanning must be ignored
            ifc.start = 1'b1;
            @(negedge clk);
            ifc.start = 1'b0;
         end
      end
      ifc.poly_valid = 1'b0;
      ifc.poly_h     = '0;

      n = 0;
      while (!ifc.done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "/done_timeout"}, 32'(ifc.done), 1);
      t_done = cyc;
      chk({nm, "/reject"}, 32'(ifc.reject), 32'(rej));
      if (!bp) begin
         chk({nm, "/done_latency"}, 32'(t_done - hs0), rej ? 258 * K : 258 * K + NB);
         if (!rej) chk({nm, "/first_byte_latency"}, 32'(first_bv - hs0), 258 * K);
      end
      @(negedge clk);
      chk({nm, "/done_one_cycle"}, 32'(ifc.done), 0);
      chk({nm, "/busy_drop"},      32'(ifc.busy), 0);
      chk({nm, "/byte_count"},     32'(n_hs), rej ? 0 : NB);
      chk({nm, "/queue_drained"},  32'(exp_q.size()), 0);
      exp_q.delete();
      bp_mode = 0;
      @(negedge clk);
   endtask

   task automatic clear_pv();
      for (int p = 0; p < K; p++) pv[p] = '0;
   endtask

   // Stimulus
   initial begin
      int c;
      rst_n          = 1'b0;
      ifc.start      = 1'b0;
      ifc.poly_valid = 1'b0;
      ifc.poly_h     = '0;
      ifc.byte_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      clear_pv();
      run_sig("all_zero", 0);

      clear_pv();
      pv[0][3] = 1'b1; pv[0][255] = 1'b1; pv[2][0] = 1'b1;
      run_sig("sparse", 0);

      clear_pv();
      for (int b = 0; b < OMEGA; b++) pv[0][b] = 1'b1;
      run_sig("exact_omega", 0);

      pv[3][5] = 1'b1;
      run_sig("overflow", 0);

      clear_pv();
      pv[0][3] = 1'b1; pv[0][255] = 1'b1; pv[2][0] = 1'b1;
      run_sig("sparse_bp", 1);

      for (int r = 0; r < 6; r++) begin
         clear_pv();
         for (int p = 0; p < K; p++)
            repeat ($urandom_range(0, 28)) pv[p][$urandom_range(0, 255)] = 1'b1;
         run_sig($sformatf("rand%0d", r), r[0]);
      end

      // Reset mid-SCAN of poly1; poly0 is dense so reject is already set
      clear_pv();
      pv[0] = '1;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start      = 1'b0;
      ifc.poly_valid = 1'b1;
      ifc.poly_h     = pv[0];
      wait_ready("mid_reset", c);
      @(negedge clk);
      ifc.poly_h = '0;
      wait_ready("mid_reset", c);
      @(negedge clk);
      ifc.poly_valid = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_reset/reject_before", 32'(ifc.reject), 1);
      chk("mid_reset/busy_before",   32'(ifc.busy),   1);
      #2 rst_n = 1'b0;
      #1 check_reset("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset("after_reset");
      clear_pv();
      run_sig("zero_after_reset", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound
   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
